// File: rtl/eth_bar_pkg.sv
// Ethernet BAR register map: word offsets and channel state encodings.
// Shared by the AXI-Lite responder and its register file.
package eth_bar_pkg;

  localparam int ETH_BAR_REG_NUM = 16;

  localparam int CTRL_MAC_EN   = 0;
  localparam int CTRL_MTU      = 1;
  localparam int CTRL_INT_MASK = 2;
  localparam int CTRL_Q_EN     = 3;

  localparam int STS_LINK   = ETH_BAR_REG_NUM / 2;
  localparam int STS_SPEED  = STS_LINK + 1;
  localparam int STS_RX_CNT = STS_LINK + 2;
  localparam int STS_TX_CNT = STS_LINK + 3;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_HALF = 3'b010,
    W_RESP = 3'b100
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'b01,
    R_RESP = 2'b10
  } rd_state_e;

endpackage

// File: rtl/eth_bar_axil_slave_regfile.sv
// RW control word storage with byte-strobe merge.
// Emits a one-cycle pulse for each word written.
module eth_bar_regfile #(
  parameter int CTRL_NUM = 8,
  parameter int IDX_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  output logic [CTRL_NUM*32-1:0]  regs,
  output logic [CTRL_NUM-1:0]     wr_pulse
);

  // merge strobed bytes into the addressed word, flag it for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      for (int i = 0; i < CTRL_NUM; i++) begin
        if (we && widx == IDX_W'(i)) begin
          wr_pulse[i] <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) regs[i*32+b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/eth_bar_axil_slave.sv
// AXI-Lite responder for the Ethernet BAR: RW control half, RO status half.
// Independent write (AW/W/B) and read (AR/R) channel state machines.
module eth_bar_axil_slave
  import eth_bar_pkg::*;
#(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 24,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
  parameter int REG_NUM         = ETH_BAR_REG_NUM
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0]   s_axil_wstrb,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  output logic [AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  output logic [REG_NUM/2*32-1:0]      ctrl_regs,
  output logic [REG_NUM/2-1:0]         ctrl_wr_pulse,
  input  logic [REG_NUM/2*32-1:0]      sts_regs
);

  localparam int CTRL_NUM = REG_NUM / 2;
  localparam int IDX_W    = $clog2(REG_NUM);
  localparam int AW       = AXIL_ADDR_WIDTH;

  wr_state_e w_state, w_next;
  rd_state_e r_state, r_next;

  logic                       aw_got, w_got;
  logic [AW-1:0]              aw_hold;
  logic [31:0]                w_hold;
  logic [AXIL_STRB_WIDTH-1:0] s_hold;

  logic                       aw_hs, w_hs, commit;
  logic [AW-1:0]              wa;
  logic [31:0]                wd;
  logic [AXIL_STRB_WIDTH-1:0] ws;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_inr, rf_we;

  logic                       ar_hs, r_inr;
  logic [IDX_W-1:0]           r_idx;
  logic [31:0]                rd_word;

  logic                       unused_ok;

  assign s_axil_awready = (w_state == W_IDLE)
                        | ((w_state == W_HALF) & ~aw_got);
  assign s_axil_wready  = (w_state == W_IDLE)
                        | ((w_state == W_HALF) & ~w_got);
  assign s_axil_bvalid  = (w_state == W_RESP);

  assign aw_hs  = s_axil_awvalid & s_axil_awready;
  assign w_hs   = s_axil_wvalid & s_axil_wready;

  assign wa     = aw_hs ? s_axil_awaddr : aw_hold;
  assign wd     = w_hs ? s_axil_wdata : w_hold;
  assign ws     = w_hs ? s_axil_wstrb : s_hold;
  assign commit = (aw_hs | aw_got) & (w_hs | w_got);

  assign w_idx  = wa[2+IDX_W-1:2];
  assign w_inr  = ~|wa[AW-1:2+IDX_W];
  assign rf_we  = commit & w_inr & ~w_idx[IDX_W-1];

  assign unused_ok = ^{wa[1:0], s_axil_araddr[1:0]};

  // write state register and half-transaction capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_hold <= '0;
      w_hold  <= '0;
      s_hold  <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) aw_hold <= s_axil_awaddr;
      if (w_hs) begin
        w_hold <= s_axil_wdata;
        s_hold <= s_axil_wstrb;
      end
      if (commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
    end
  end

  // write next-state
  always_comb begin
    w_next = w_state;
    unique case (1'b1)
      w_state[0]: begin
        if (aw_hs & w_hs)      w_next = W_RESP;
        else if (aw_hs | w_hs) w_next = W_HALF;
      end
      w_state[1]: if (commit) w_next = W_RESP;
      w_state[2]: if (s_axil_bready) w_next = W_IDLE;
      default:    w_next = W_IDLE;
    endcase
  end

  eth_bar_regfile #(
    .CTRL_NUM (CTRL_NUM),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .widx     (w_idx),
    .wdata    (wd),
    .wstrb    (ws),
    .regs     (ctrl_regs),
    .wr_pulse (ctrl_wr_pulse)
  );

  assign s_axil_arready = (r_state == R_IDLE);
  assign s_axil_rvalid  = (r_state == R_RESP);
  assign ar_hs = s_axil_arvalid & s_axil_arready;
  assign r_idx = s_axil_araddr[2+IDX_W-1:2];
  assign r_inr = ~|s_axil_araddr[AW-1:2+IDX_W];

  // read mux: control words, status words, zero out of range
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < CTRL_NUM; i++) begin
      if (r_inr && r_idx == IDX_W'(i))
        rd_word = ctrl_regs[i*32 +: 32];
      if (r_inr && r_idx == IDX_W'(i + CTRL_NUM))
        rd_word = sts_regs[i*32 +: 32];
    end
  end

  // read state register and response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= R_IDLE;
      s_axil_rdata <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) s_axil_rdata <= rd_word;
    end
  end

  // read next-state
  always_comb begin
    r_next = r_state;
    unique case (1'b1)
      r_state[0]: if (ar_hs) r_next = R_RESP;
      r_state[1]: if (s_axil_rready) r_next = R_IDLE;
      default:    r_next = R_IDLE;
    endcase
  end

endmodule

// File: doc/eth_bar_axil_slave.md
# eth_bar_axil_slave

AXI-Lite responder for the Ethernet BAR register space. It terminates the AXIL master port of the PCIe PIO path. It accepts single-beat writes (AW/W/B) and reads (AR/R), stores a bank of RW control registers with byte strobes, and returns live status words on the RO half of the map. It sits on the Ethernet side, between the PIO AXIL master and the MAC/queue control logic.

## Interface
- AXIL_DATA_WIDTH, 32, data width; only 32 is supported.
- AXIL_ADDR_WIDTH, 24, byte address width.
- AXIL_STRB_WIDTH, AXIL_DATA_WIDTH/8, write strobe width.
- REG_NUM, 16, number of 32-bit words; power of 2, ≥2. Words 0..REG_NUM/2-1 are RW control; the rest are RO status.

- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axil_awaddr  in  AXIL_ADDR_WIDTH  write byte address.
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte enables.
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake.
- s_axil_bvalid / s_axil_bready  out / in  1  write response. There is no bresp.
- s_axil_araddr  in  AXIL_ADDR_WIDTH  read byte address.
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rvalid / s_axil_rready  out / in  1  read response. There is no rresp.
- ctrl_regs  out  REG_NUM/2*32  flattened RW registers; word i is at [32i+31:32i].
- ctrl_wr_pulse  out  REG_NUM/2  one-cycle pulse per RW word written.
- sts_regs  in  REG_NUM/2*32  flattened RO status words, sampled on read.

## Operation
- Decode: idx = addr[2+log2(REG_NUM)-1:2]. addr[1:0] is ignored. Any set bit of addr above the map makes the access out of range.
- Write channel FSM has three states:
  - W_IDLE: awready=1, wready=1. AW and W are captured independently into aw_hold and w_hold.
    - If both handshake in the same cycle, go to W_RESP.
    - If only one handshakes, go to W_HALF.
  - W_HALF: the ready of the captured channel is 0; the other channel's ready is 1. Its handshake commits the write and goes to W_RESP.
  - W_RESP: bvalid=1, awready=0, wready=0. On bready, go to W_IDLE.
- Commit happens on the edge that completes the AW+W pair.
  - For an in-range RW word, each byte b with wstrb[b]=1 is replaced. ctrl_wr_pulse[idx] is 1 for the following cycle.
  - Writes to RO or out-of-range words are dropped, but B is still returned.
- Read channel FSM has two states:
  - R_IDLE: arready=1. On handshake, register rdata and go to R_RESP.
    - RW word: current ctrl value, taken before any commit on the same edge.
    - RO word: sts_regs word at that edge.
    - Out of range: 32'h0.
  - R_RESP: rvalid=1, arready=0, rdata held stable. On rready, go to R_IDLE.
- Read and write channels are fully independent. Both may run concurrently.

## Timing
- Reset values: bvalid=0, rvalid=0, rdata=0, ctrl_regs=0, ctrl_wr_pulse=0, FSMs in IDLE.
  - Therefore awready=1, wready=1 and arready=1 from the first cycle after reset release.
- Write latency: the bvalid rise and ctrl_regs update become visible in the cycle after the completing handshake (1 cycle).
  - Back-to-back write throughput is 1 per 2 cycles when bready=1.
- Read latency: rvalid/rdata are valid in the cycle after the AR handshake.
  - Throughput is 1 per 2 cycles when rready=1.
- Master holds bready/rready low: the response stays asserted indefinitely. No new AW, W or AR is accepted meanwhile.
- Reset mid-transaction: an asynchronous drop returns everything to reset values. Captured halves are discarded.
- All outputs are registered or decoded from state only. There is no combinational path from valid to ready.

## Structure
- Package eth_bar_pkg:
  - ETH_BAR_REG_NUM.
  - Named word offsets: CTRL_MAC_EN=0, CTRL_MTU=1, CTRL_INT_MASK=2, …; STS_LINK=REG_NUM/2, ….
  - Write and read state localparams (one-hot, 3 and 2 bits).
- Sub-module eth_bar_regfile: RW storage with byte-strobe merge and wr_pulse generation.
  - Channel FSMs, decode and the read mux stay in the top module.

## Test plan
- Reset:
  - Assert rst_n=0 mid-W_HALF (AW captured) → bvalid=0, ctrl_regs=0, awready=wready=1 after release.
  - A subsequent full write to word 0 completes normally.
- Simultaneous AW+W:
  - addr 0x4, wdata 0x1234_5678, wstrb 0xF → next cycle bvalid=1, ctrl word1=0x1234_5678, ctrl_wr_pulse=2'b10 in the low bits for one cycle.
- AW then W three cycles later:
  - addr 0x8, wstrb 0x3, wdata 0xAAAA_BBBB over an old value of 0x1111_2222 → word2=0x1111_BBBB.
  - awready=0 and wready=1 while in W_HALF.
- Read RO and out of range:
  - sts word0=0xCAFE_0001, read addr 0x20 (REG_NUM=16) → rdata=0xCAFE_0001.
  - Read addr 0x40 → rdata=0. Writing 0x20 leaves status unchanged and still returns B.
- Backpressure:
  - rready=0 for 5 cycles → rvalid and rdata stable and arready=0 throughout. Release → rvalid drops the next cycle.
  - Same check on B with bready.
- Concurrent read/write same word:
  - Write 0x5 and read of word 0 handshaking on the same edge → rdata=old value. A following read returns 0x5.
